memarbiter: RTL and testbench

MEMARBITER -- requirements
Module: memarbiter

---
 rtl/memarbiter_if.sv | 36 +++
 rtl/memarbiter.sv | 123 ++++++++++++
 tb/tb_memarbiter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/memarbiter_if.sv
// Bundle of requester-side and memory-side signals for the two-port memory arbiter.
// The arbiter uses the master view; the environment (CPU ports + memory) uses the slave view.
interface memarbiter_if #(
    parameter int WORDSIZE = 64
);
    logic                ireq;
    logic [WORDSIZE-1:0] iaddr;
    logic [WORDSIZE-1:0] irdata;
    logic                idone;

    logic                dreq;
    logic                dwe;
    logic [WORDSIZE-1:0] daddr;
    logic [WORDSIZE-1:0] dwdata;
    logic [WORDSIZE-1:0] drdata;
    logic                ddone;

    logic                err;

    logic                mreq;
    logic                mwe;
    logic [WORDSIZE-1:0] maddr;
    logic [WORDSIZE-1:0] mwdata;
    logic [WORDSIZE-1:0] mrdata;
    logic                mack;

    modport master (
        input  ireq, iaddr, dreq, dwe, daddr, dwdata, mrdata, mack,
        output irdata, idone, drdata, ddone, err, mreq, mwe, maddr, mwdata
    );

    modport slave (
        output ireq, iaddr, dreq, dwe, daddr, dwdata, mrdata, mack,
        input  irdata, idone, drdata, ddone, err, mreq, mwe, maddr, mwdata
    );
endinterface

// File: rtl/memarbiter.sv
// Round-robin arbiter sharing one single-port memory between an instruction-fetch
// port and a data port, with a per-access acknowledge timeout.
//
// state | meaning
// IDLE  | waiting for a request, arbitrates ties round-robin
// IBUSY | fetch access on the memory bus, waiting for mack
// DBUSY | data access on the memory bus, waiting for mack
// DONE  | one-cycle completion pulse to the granted side
module memarbiter #(
    parameter int WORDSIZE = 64,
    parameter int TIMEOUT  = 15
) (
    input logic          clk,
    input logic          rst,
    memarbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, IBUSY, DBUSY, DONE} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic                last_d_q, last_d_d;
    logic                sel_d_q, sel_d_d;
    logic                err_q, err_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                mwe_q, mwe_d;
    logic [WORDSIZE-1:0] maddr_q, maddr_d;
    logic [WORDSIZE-1:0] mwdata_q, mwdata_d;
    logic [WORDSIZE-1:0] irdata_q, irdata_d;
    logic [WORDSIZE-1:0] drdata_q, drdata_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
            sel_d_q  <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            mwe_q    <= 1'b0;
            maddr_q  <= '0;
            mwdata_q <= '0;
            irdata_q <= '0;
            drdata_q <= '0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            sel_d_q  <= sel_d_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            mwe_q    <= mwe_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
            irdata_q <= irdata_d;
            drdata_q <= drdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        sel_d_d  = sel_d_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        mwe_d    = mwe_q;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;
        irdata_d = irdata_q;
        drdata_d = drdata_q;

        case (state_q)
            IDLE: begin
                // Data wins unless a fetch is also pending and data had the last grant.
                if (bus.dreq && (!bus.ireq || !last_d_q)) begin
                    state_d  = DBUSY;
                    sel_d_d  = 1'b1;
                    err_d    = 1'b0;
                    cnt_d    = '0;
                    mwe_d    = bus.dwe;
                    maddr_d  = bus.daddr;
                    mwdata_d = bus.dwdata;
                end else if (bus.ireq) begin
                    state_d  = IBUSY;
                    sel_d_d  = 1'b0;
                    err_d    = 1'b0;
                    cnt_d    = '0;
                    mwe_d    = 1'b0;
                    maddr_d  = bus.iaddr;
                    mwdata_d = '0;
                end
            end
            IBUSY, DBUSY: begin
                if (bus.mack) begin
                    state_d = DONE;
                    if (sel_d_q) drdata_d = bus.mrdata;
                    else         irdata_d = bus.mrdata;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                        if (sel_d_q) drdata_d = '0;
                        else         irdata_d = '0;
                    end
                end
            end
            DONE: begin
                state_d  = IDLE;
                last_d_d = sel_d_q;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.mreq   = (state_q == IBUSY) || (state_q == DBUSY);
    assign bus.mwe    = mwe_q;
    assign bus.maddr  = maddr_q;
    assign bus.mwdata = mwdata_q;
    assign bus.irdata = irdata_q;
    assign bus.drdata = drdata_q;
    assign bus.idone  = (state_q == DONE) && !sel_d_q;
    assign bus.ddone  = (state_q == DONE) && sel_d_q;
    assign bus.err    = (state_q == DONE) && err_q;
endmodule

// File: tb/tb_memarbiter.sv
// Directed bench for memarbiter: single fetch, tie-break, alternation, timeout,
// asynchronous reset mid-access and requester drop while busy.
module tb_memarbiter;
    logic clk;
    logic rst;
    int   vec;
    int   errs;

    memarbiter_if #(.WORDSIZE(64)) bus ();

    memarbiter #(.WORDSIZE(64), .TIMEOUT(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #3;
        vec++; if (bus.mreq !== 1'b0)     begin errs++; $display("FAIL reset_mreq: got %b exp 0", bus.mreq); end
        vec++; if (bus.mwe !== 1'b0)      begin errs++; $display("FAIL reset_mwe: got %b exp 0", bus.mwe); end
        vec++; if (bus.maddr !== 64'h0)   begin errs++; $display("FAIL reset_maddr: got %h exp 0", bus.maddr); end
        vec++; if (bus.mwdata !== 64'h0)  begin errs++; $display("FAIL reset_mwdata: got %h exp 0", bus.mwdata); end
        vec++; if (bus.irdata !== 64'h0)  begin errs++; $display("FAIL reset_irdata: got %h exp 0", bus.irdata); end
        vec++; if (bus.drdata !== 64'h0)  begin errs++; $display("FAIL reset_drdata: got %h exp 0", bus.drdata); end
        vec++; if ({bus.idone, bus.ddone, bus.err} !== 3'b000)
            begin errs++; $display("FAIL reset_done: got %b exp 000", {bus.idone, bus.ddone, bus.err}); end
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_fetch();
        bus.ireq = 1'b1; bus.iaddr = 64'h40;
        tick();
        vec++; if (bus.mreq !== 1'b1)    begin errs++; $display("FAIL fetch_mreq: got %b exp 1", bus.mreq); end
        vec++; if (bus.mwe !== 1'b0)     begin errs++; $display("FAIL fetch_mwe: got %b exp 0", bus.mwe); end
        vec++; if (bus.maddr !== 64'h40) begin errs++; $display("FAIL fetch_maddr: got %h exp 40", bus.maddr); end
        bus.mack = 1'b1; bus.mrdata = 64'h8B020020;
        tick();
        bus.mack = 1'b0; bus.ireq = 1'b0;
        vec++; if (bus.idone !== 1'b1)   begin errs++; $display("FAIL fetch_idone: got %b exp 1", bus.idone); end
        vec++; if (bus.irdata !== 64'h8B020020)
            begin errs++; $display("FAIL fetch_irdata: got %h exp 8b020020", bus.irdata); end
        vec++; if ({bus.ddone, bus.err, bus.mreq} !== 3'b000)
            begin errs++; $display("FAIL fetch_done_misc: got %b exp 000", {bus.ddone, bus.err, bus.mreq}); end
        tick();
        vec++; if (bus.idone !== 1'b0)   begin errs++; $display("FAIL fetch_idone_pulse: got %b exp 0", bus.idone); end
        // mack while idle must be ignored
        bus.mack = 1'b1; bus.mrdata = 64'hDEAD;
        tick();
        tick();
        bus.mack = 1'b0;
        vec++; if ({bus.idone, bus.ddone, bus.mreq} !== 3'b000)
            begin errs++; $display("FAIL idle_mack: got %b exp 000", {bus.idone, bus.ddone, bus.mreq}); end
        vec++; if (bus.irdata !== 64'h8B020020)
            begin errs++; $display("FAIL irdata_hold: got %h exp 8b020020", bus.irdata); end
    endtask

    task automatic test_tie();
        rst = 1'b0;
        #3;
        rst = 1'b1;
        bus.ireq = 1'b1; bus.iaddr = 64'h200;
        bus.dreq = 1'b1; bus.dwe = 1'b1; bus.daddr = 64'h100; bus.dwdata = 64'h55;
        tick();
        vec++; if (bus.mreq !== 1'b1)      begin errs++; $display("FAIL tie_mreq: got %b exp 1", bus.mreq); end
        vec++; if (bus.mwe !== 1'b1)       begin errs++; $display("FAIL tie_mwe: got %b exp 1", bus.mwe); end
        vec++; if (bus.maddr !== 64'h100)  begin errs++; $display("FAIL tie_maddr: got %h exp 100", bus.maddr); end
        vec++; if (bus.mwdata !== 64'h55)  begin errs++; $display("FAIL tie_mwdata: got %h exp 55", bus.mwdata); end
        bus.mack = 1'b1; bus.mrdata = 64'hAAAA;
        tick();
        bus.mack = 1'b0; bus.dreq = 1'b0;
        vec++; if ({bus.ddone, bus.idone} !== 2'b10)
            begin errs++; $display("FAIL tie_ddone: got %b exp 10", {bus.ddone, bus.idone}); end
        tick();
        vec++; if (bus.mreq !== 1'b0)      begin errs++; $display("FAIL tie_idle_gap: got %b exp 0", bus.mreq); end
        tick();
        vec++; if (bus.mreq !== 1'b1)      begin errs++; $display("FAIL tie_i_mreq: got %b exp 1", bus.mreq); end
        vec++; if (bus.maddr !== 64'h200)  begin errs++; $display("FAIL tie_i_maddr: got %h exp 200", bus.maddr); end
        vec++; if (bus.mwe !== 1'b0)       begin errs++; $display("FAIL tie_i_mwe: got %b exp 0", bus.mwe); end
        bus.mack = 1'b1; bus.mrdata = 64'h1234;
        tick();
        bus.mack = 1'b0; bus.ireq = 1'b0;
        vec++; if ({bus.ddone, bus.idone} !== 2'b01)
            begin errs++; $display("FAIL tie_idone: got %b exp 01", {bus.ddone, bus.idone}); end
        vec++; if (bus.irdata !== 64'h1234) begin errs++; $display("FAIL tie_irdata: got %h exp 1234", bus.irdata); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [5:0] exp_data;
        int         n;
        exp_data = 6'b010101;   // bit k set: access k must be a data grant
        bus.ireq = 1'b1; bus.iaddr = 64'h600;
        bus.dreq = 1'b1; bus.dwe = 1'b1; bus.daddr = 64'h700; bus.dwdata = 64'h99;
        for (int k = 0; k < 6; k++) begin
            n = 0;
            while (bus.mreq !== 1'b1 && n < 5) begin tick(); n++; end
            vec++; if (bus.mreq !== 1'b1)
                begin errs++; $display("FAIL b2b_wait[%0d]: mreq got %b exp 1", k, bus.mreq); end
            vec++; if (bus.maddr !== (exp_data[k] ? 64'h700 : 64'h600))
                begin errs++; $display("FAIL b2b_grant[%0d]: maddr got %h exp %h", k, bus.maddr,
                                       exp_data[k] ? 64'h700 : 64'h600); end
            bus.mack = 1'b1; bus.mrdata = 64'hC0 + 64'(k);
            tick();
            bus.mack = 1'b0;
            vec++; if ({bus.ddone, bus.idone} !== (exp_data[k] ? 2'b10 : 2'b01))
                begin errs++; $display("FAIL b2b_done[%0d]: got %b exp %b", k, {bus.ddone, bus.idone},
                                       exp_data[k] ? 2'b10 : 2'b01); end
            if (k == 5) begin bus.ireq = 1'b0; bus.dreq = 1'b0; end
        end
        tick();
        vec++; if (bus.drdata !== 64'hC4) begin errs++; $display("FAIL b2b_drdata: got %h exp c4", bus.drdata); end
    endtask

    task automatic test_timeout();
        int n;
        bus.dreq = 1'b1; bus.dwe = 1'b0; bus.daddr = 64'h80;
        tick();
        n = 0;
        while (bus.mreq === 1'b1 && n < 40) begin n++; tick(); end
        bus.dreq = 1'b0;
        vec++; if (n !== 15)             begin errs++; $display("FAIL to_mreq_cycles: got %0d exp 15", n); end
        vec++; if ({bus.ddone, bus.err, bus.idone} !== 3'b110)
            begin errs++; $display("FAIL to_done_err: got %b exp 110", {bus.ddone, bus.err, bus.idone}); end
        vec++; if (bus.drdata !== 64'h0) begin errs++; $display("FAIL to_drdata: got %h exp 0", bus.drdata); end
        tick();
        vec++; if ({bus.ddone, bus.err} !== 2'b00)
            begin errs++; $display("FAIL to_pulse: got %b exp 00", {bus.ddone, bus.err}); end
    endtask

    task automatic test_reset_mid();
        bus.dreq = 1'b1; bus.dwe = 1'b0; bus.daddr = 64'h300;
        tick();
        vec++; if (bus.mreq !== 1'b1)  begin errs++; $display("FAIL rm_busy: got %b exp 1", bus.mreq); end
        #2;
        rst = 1'b0;
        #1;
        vec++; if (bus.mreq !== 1'b0)  begin errs++; $display("FAIL rm_async_mreq: got %b exp 0", bus.mreq); end
        tick();
        vec++; if ({bus.ddone, bus.mreq, bus.maddr} !== {2'b00, 64'h0})
            begin errs++; $display("FAIL rm_held: got %b/%h exp 00/0", {bus.ddone, bus.mreq}, bus.maddr); end
        #3;
        rst = 1'b1;
        tick();
        vec++; if (bus.mreq !== 1'b1)    begin errs++; $display("FAIL rm_restart: got %b exp 1", bus.mreq); end
        vec++; if (bus.maddr !== 64'h300) begin errs++; $display("FAIL rm_maddr: got %h exp 300", bus.maddr); end
        bus.mack = 1'b1; bus.mrdata = 64'h3333;
        tick();
        bus.mack = 1'b0; bus.dreq = 1'b0;
        vec++; if (bus.ddone !== 1'b1 || bus.drdata !== 64'h3333)
            begin errs++; $display("FAIL rm_done: got %b/%h exp 1/3333", bus.ddone, bus.drdata); end
        tick();
    endtask

    task automatic test_drop();
        bus.ireq = 1'b1; bus.iaddr = 64'h440;
        tick();
        bus.ireq = 1'b0;
        for (int k = 0; k < 3; k++) begin
            vec++; if (bus.mreq !== 1'b1 || bus.maddr !== 64'h440)
                begin errs++; $display("FAIL drop_busy[%0d]: got %b/%h exp 1/440", k, bus.mreq, bus.maddr); end
            tick();
        end
        bus.mack = 1'b1; bus.mrdata = 64'h77;
        tick();
        bus.mack = 1'b0;
        vec++; if ({bus.idone, bus.err} !== 2'b10 || bus.irdata !== 64'h77)
            begin errs++; $display("FAIL drop_done: got %b/%h exp 10/77", {bus.idone, bus.err}, bus.irdata); end
        vec++; if (bus.maddr !== 64'h440) begin errs++; $display("FAIL drop_maddr: got %h exp 440", bus.maddr); end
        tick();
        vec++; if ({bus.mreq, bus.idone} !== 2'b00)
            begin errs++; $display("FAIL drop_idle: got %b exp 00", {bus.mreq, bus.idone}); end
    endtask

    initial begin
        vec = 0; errs = 0;
        bus.ireq = 1'b0; bus.iaddr = '0;
        bus.dreq = 1'b0; bus.dwe = 1'b0; bus.daddr = '0; bus.dwdata = '0;
        bus.mrdata = '0; bus.mack = 1'b0;
        test_reset();
        test_fetch();
        test_tie();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_drop();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
